dualport_ram_param: RTL and testbench

//  Parametrised true dual-port RAM. Two independent read/write ports on one clock.

---
 rtl/dualport_ram_param.sv | 188 ++++++++++++++++++
 tb/tb_dualport_ram_param.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dualport_ram_param.sv
// Parametrised true dual-port RAM with byte enables, selectable read-during-write
// behaviour, optional output register, hardware clear after reset and collision flag.
module dualport_ram_param #(
    parameter int DATA_W  = 128,
    parameter int ADDR_W  = 3,
    parameter int WR_MODE = 0,
    parameter int OUT_REG = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_a,
    input  logic                  wr_en_a,
    input  logic [DATA_W/8-1:0]   be_a,
    input  logic [ADDR_W-1:0]     addr_a,
    input  logic [DATA_W-1:0]     data_in_a,
    output logic [DATA_W-1:0]     data_out_a,
    output logic                  valid_a,
    input  logic                  en_b,
    input  logic                  wr_en_b,
    input  logic [DATA_W/8-1:0]   be_b,
    input  logic [ADDR_W-1:0]     addr_b,
    input  logic [DATA_W-1:0]     data_in_b,
    output logic [DATA_W-1:0]     data_out_b,
    output logic                  valid_b,
    output logic                  init_done,
    output logic                  collision
);

    localparam int DEPTH  = 2**ADDR_W;
    localparam int NBYTES = DATA_W/8;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_cnt;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_run;
    logic                w_acc_a;
    logic                w_acc_b;
    logic                w_wr_a;
    logic                w_wr_b;
    logic                w_same_addr;
    logic [DATA_W-1:0]   w_old_a;
    logic [DATA_W-1:0]   w_old_b;
    logic [DATA_W-1:0]   w_new_a;
    logic [DATA_W-1:0]   w_new_b;

    logic [DATA_W-1:0]   r_d1_a;
    logic [DATA_W-1:0]   r_d1_b;
    logic                r_v1_a;
    logic                r_v1_b;
    logic                r_coll;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_CLEAR) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (r_state == ST_CLEAR && r_cnt == ADDR_W'(DEPTH-1)) begin
            w_state_next = ST_RUN;
        end
    end

    assign w_run       = (r_state == ST_RUN);
    assign init_done   = w_run;
    assign w_acc_a     = w_run & en_a;
    assign w_acc_b     = w_run & en_b;
    assign w_wr_a      = w_acc_a & wr_en_a;
    assign w_wr_b      = w_acc_b & wr_en_b;
    assign w_same_addr = (addr_a == addr_b);
    assign w_old_a     = r_mem[addr_a];
    assign w_old_b     = r_mem[addr_b];

    // Post-write word as it will sit in memory, including the other port's bytes (A wins ties).
    always_comb begin
        w_new_a = w_old_a;
        w_new_b = w_old_b;
        for (int i = 0; i < NBYTES; i++) begin
            if (w_wr_b && w_same_addr && be_b[i]) w_new_a[8*i +: 8] = data_in_b[8*i +: 8];
            if (w_wr_a && be_a[i])                w_new_a[8*i +: 8] = data_in_a[8*i +: 8];
            if (w_wr_b && be_b[i])                w_new_b[8*i +: 8] = data_in_b[8*i +: 8];
            if (w_wr_a && w_same_addr && be_a[i]) w_new_b[8*i +: 8] = data_in_a[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!w_run) begin
            r_mem[r_cnt] <= '0;
        end else begin
            for (int i = 0; i < NBYTES; i++) begin
                if (w_wr_b && be_b[i]) r_mem[addr_b][8*i +: 8] <= data_in_b[8*i +: 8];
                if (w_wr_a && be_a[i]) r_mem[addr_a][8*i +: 8] <= data_in_a[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d1_a <= '0;
            r_v1_a <= 1'b0;
        end else begin
            r_v1_a <= 1'b0;
            if (w_acc_a) begin
                if (!wr_en_a || WR_MODE == 1) begin
                    r_d1_a <= w_old_a;
                    r_v1_a <= 1'b1;
                end else if (WR_MODE == 2) begin
                    r_d1_a <= w_new_a;
                    r_v1_a <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d1_b <= '0;
            r_v1_b <= 1'b0;
        end else begin
            r_v1_b <= 1'b0;
            if (w_acc_b) begin
                if (!wr_en_b || WR_MODE == 1) begin
                    r_d1_b <= w_old_b;
                    r_v1_b <= 1'b1;
                end else if (WR_MODE == 2) begin
                    r_d1_b <= w_new_b;
                    r_v1_b <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_coll <= 1'b0;
        end else begin
            r_coll <= w_acc_a & w_acc_b & w_same_addr & (wr_en_a | wr_en_b);
        end
    end

    assign collision = r_coll;

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_W-1:0] r_d2_a;
            logic [DATA_W-1:0] r_d2_b;
            logic              r_v2_a;
            logic              r_v2_b;

            // Second stage only reloads on a valid result so data_out holds between strobes.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_d2_a <= '0;
                    r_d2_b <= '0;
                    r_v2_a <= 1'b0;
                    r_v2_b <= 1'b0;
                end else begin
                    r_v2_a <= r_v1_a;
                    r_v2_b <= r_v1_b;
                    if (r_v1_a) r_d2_a <= r_d1_a;
                    if (r_v1_b) r_d2_b <= r_d1_b;
                end
            end

            assign data_out_a = r_d2_a;
            assign data_out_b = r_d2_b;
            assign valid_a    = r_v2_a;
            assign valid_b    = r_v2_b;
        end else begin : g_noreg
            assign data_out_a = r_d1_a;
            assign data_out_b = r_d1_b;
            assign valid_a    = r_v1_a;
            assign valid_b    = r_v1_b;
        end
    endgenerate

endmodule

// File: tb/tb_dualport_ram_param.sv
// Scoreboard bench for dualport_ram_param: three instances cover NO_CHANGE/OUT_REG0,
// READ_FIRST/OUT_REG1 and WRITE_FIRST/OUT_REG0, all driven by the same stimulus.
module tb_dualport_ram_param;

    localparam int DW = 128;
    localparam int AW = 3;
    localparam int NB = DW/8;
    localparam int NI = 3;

    typedef struct {
        int            inst;
        int            port;
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enA, wrA, enB, wrB;
    logic [NB-1:0] beA, beB;
    logic [AW-1:0] addrA, addrB;
    logic [DW-1:0] dinA, dinB;

    logic [DW-1:0] doutA [NI];
    logic [DW-1:0] doutB [NI];
    logic          vA [NI];
    logic          vB [NI];
    logic          coll [NI];
    logic          initDone [NI];

    int            nChecks = 0;
    int            nPass   = 0;
    int            cyc     = 0;
    int            clrCnt  = 0;
    bit            mRun    = 1'b0;
    logic [DW-1:0] mdl [8];
    exp_t          expQ [$];

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            dualport_ram_param #(
                .DATA_W (DW),
                .ADDR_W (AW),
                .WR_MODE(g),
                .OUT_REG((g == 1) ? 1 : 0)
            ) dut (
                .clk       (clk),
                .rst       (rst),
                .en_a      (enA),
                .wr_en_a   (wrA),
                .be_a      (beA),
                .addr_a    (addrA),
                .data_in_a (dinA),
                .data_out_a(doutA[g]),
                .valid_a   (vA[g]),
                .en_b      (enB),
                .wr_en_b   (wrB),
                .be_b      (beB),
                .addr_b    (addrB),
                .data_in_b (dinB),
                .data_out_b(doutB[g]),
                .valid_b   (vB[g]),
                .init_done (initDone[g]),
                .collision (coll[g])
            );
        end
    endgenerate

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        nChecks++;
        if (obs === expv) nPass++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, obs, expv);
    endtask

    function automatic logic [DW-1:0] mergeBytes(input logic [DW-1:0] old, input logic [DW-1:0] din,
                                                 input logic [NB-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < NB; i++) if (be[i]) r[8*i +: 8] = din[8*i +: 8];
        return r;
    endfunction

    task automatic pushExp(input int g, input int p, input bit e, input bit w,
                           input logic [DW-1:0] old, input logic [DW-1:0] post);
        exp_t x;
        if (!e) return;
        x.inst = g;
        x.port = p;
        x.due  = cyc + 1 + ((g == 1) ? 1 : 0);
        if (!w)          x.data = old;
        else if (g == 1) x.data = old;
        else if (g == 2) x.data = post;
        else return;
        expQ.push_back(x);
    endtask

    // Called just after a negedge: compares valids/data due this cycle, collision and init_done.
    task automatic scanOutputs(input bit expColl);
        for (int g = 0; g < NI; g++) begin
            for (int p = 0; p < 2; p++) begin
                int            idx;
                logic          v;
                logic [DW-1:0] d;
                idx = -1;
                v   = (p == 0) ? vA[g] : vB[g];
                d   = (p == 0) ? doutA[g] : doutB[g];
                for (int k = 0; k < expQ.size(); k++) begin
                    if (expQ[k].inst == g && expQ[k].port == p && expQ[k].due == cyc) begin
                        idx = k;
                        break;
                    end
                end
                checkOutput($sformatf("i%0d p%0d valid @%0d", g, p, cyc), DW'(v), DW'(idx >= 0));
                if (idx >= 0) begin
                    if (v) checkOutput($sformatf("i%0d p%0d data @%0d", g, p, cyc), d, expQ[idx].data);
                    expQ.delete(idx);
                end
            end
            checkOutput($sformatf("i%0d collision @%0d", g, cyc), DW'(coll[g]), DW'(expColl));
            checkOutput($sformatf("i%0d init_done @%0d", g, cyc), DW'(initDone[g]), DW'(mRun));
        end
    endtask

    task automatic applyStimulus(input bit eA, input bit wA, input logic [NB-1:0] bA,
                                 input logic [AW-1:0] aA, input logic [DW-1:0] dA,
                                 input bit eB, input bit wB, input logic [NB-1:0] bB,
                                 input logic [AW-1:0] aB, input logic [DW-1:0] dB);
        logic [DW-1:0] nxt [8];
        bit            expColl;
        enA = eA; wrA = wA; beA = bA; addrA = aA; dinA = dA;
        enB = eB; wrB = wB; beB = bB; addrB = aB; dinB = dB;
        nxt = mdl;
        if (mRun && eB && wB) nxt[aB] = mergeBytes(nxt[aB], dB, bB);
        if (mRun && eA && wA) nxt[aA] = mergeBytes(nxt[aA], dA, bA);
        if (mRun) begin
            for (int g = 0; g < NI; g++) begin
                pushExp(g, 0, eA, wA, mdl[aA], nxt[aA]);
                pushExp(g, 1, eB, wB, mdl[aB], nxt[aB]);
            end
        end
        expColl = mRun && eA && eB && (aA == aB) && (wA || wB);
        mdl = nxt;
        @(posedge clk);
        cyc++;
        if (!rst && !mRun) begin
            clrCnt++;
            if (clrCnt == 8) mRun = 1'b1;
        end
        @(negedge clk);
        scanOutputs(expColl);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
    endtask

    task automatic doReset(input int nHold);
        rst    = 1'b1;
        mRun   = 1'b0;
        clrCnt = 0;
        expQ.delete();
        for (int i = 0; i < 8; i++) mdl[i] = '0;
        #1;
        for (int g = 0; g < NI; g++) begin
            checkOutput($sformatf("i%0d rst data_out_a", g), doutA[g], '0);
            checkOutput($sformatf("i%0d rst valid_b", g), DW'(vB[g]), '0);
            checkOutput($sformatf("i%0d rst init_done", g), DW'(initDone[g]), '0);
        end
        idle(nHold);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [DW-1:0] pA5, p11, p22, p33, p44;
        pA5 = {NB{8'hA5}};
        p11 = {NB{8'h11}};
        p22 = {NB{8'h22}};
        p33 = {NB{8'h33}};
        p44 = {NB{8'h44}};
        enA = 0; wrA = 0; beA = '0; addrA = '0; dinA = '0;
        enB = 0; wrB = 0; beB = '0; addrB = '0; dinB = '0;
        @(negedge clk);
        doReset(2);

        // Accesses during CLEAR must be ignored; init_done checked every cycle.
        for (int i = 0; i < 8; i++)
            applyStimulus(1, 1, '1, AW'(i), {4{$urandom}}, 1, (i % 2) == 0, '1, AW'(i), {4{$urandom}});

        for (int i = 0; i < 8; i++)
            applyStimulus(1, 0, '0, AW'(i), '0, 1, 0, '0, AW'(7 - i), '0);
        idle(2);

        applyStimulus(1, 1, '1, 3, pA5, 0, 0, '0, '0, '0);
        applyStimulus(0, 0, '0, '0, '0, 1, 0, '0, 3, '0);
        idle(2);

        applyStimulus(1, 1, 16'h00F0, 4, '1, 0, 0, '0, '0, '0);
        applyStimulus(1, 0, '0, 4, '0, 0, 0, '0, '0, '0);
        idle(2);

        applyStimulus(1, 1, '1, 5, p11, 1, 1, '1, 5, p22);
        applyStimulus(1, 0, '0, 5, '0, 0, 0, '0, '0, '0);
        idle(2);
        applyStimulus(1, 1, 16'h00FF, 5, p11, 1, 1, '1, 5, p22);
        applyStimulus(0, 0, '0, '0, '0, 1, 0, '0, 5, '0);
        idle(2);

        applyStimulus(1, 1, '1, 2, p33, 0, 0, '0, '0, '0);
        applyStimulus(1, 1, '1, 2, p44, 1, 0, '0, 2, '0);
        applyStimulus(1, 0, '0, 2, '0, 0, 0, '0, '0, '0);
        idle(2);

        for (int i = 0; i < 40; i++)
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), NB'($urandom),
                          AW'($urandom_range(0, 7)), {$urandom, $urandom, $urandom, $urandom},
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), NB'($urandom),
                          AW'($urandom_range(0, 7)), {$urandom, $urandom, $urandom, $urandom});
        idle(3);

        // Reset with reads still in flight, then interrupt the clear at count 4.
        applyStimulus(1, 0, '0, 1, '0, 1, 0, '0, 6, '0);
        doReset(1);
        idle(4);
        doReset(1);
        for (int i = 0; i < 20; i++)
            applyStimulus(1, 0, '0, AW'(i), '0, 1, 0, '0, AW'(i + 3), '0);
        idle(3);
        checkOutput("scoreboard drained", DW'(expQ.size()), '0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
